ps2_dev_tx: RTL and testbench

- Device-side PS/2 transmitter: the keyboard/mouse end of the PS/2 link whose host end lives in the Next core.
- Accepts scan-code bytes through a valid/ready interface and buffers them in an internal FIFO.
- Serialises each byte as a standard 11-bit PS/2 frame, generating the PS/2 clock itself.
- Honours host inhibit and request-to-send on the shared open-drain lines, retransmitting any aborted byte.

---
 rtl/ps2_dev_tx.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_dev_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_dev_tx.sv
// Device-side PS/2 transmitter: queues scan-code bytes in a small FIFO and sends
// each one as an 11-bit frame on self-clocked open-drain lines, retrying after host inhibit.
module ps2_dev_tx #(
    parameter int CLK_HALF = 1000,
    parameter int FIFO_AW  = 3
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               busy,
    output logic               ps2_clk_o,
    output logic               ps2_data_o,
    input  logic               ps2_clk_i,
    input  logic               ps2_data_i
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = $clog2(2 * CLK_HALF);
    localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLK_HALF - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(2 * CLK_HALF - 1);
    localparam logic [CNT_W-1:0]   BLANK     = CNT_W'(3);
    localparam logic [FIFO_AW:0]   DEPTH_L   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [3:0]         LAST_BIT  = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IDLE_CHK,
        S_HIGH,
        S_LOW,
        S_ABORT,
        S_GAP
    } state_t;

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    logic [1:0] r_clk_sync;
    logic [1:0] r_dat_sync;
    logic       w_clk_s;
    logic       w_dat_s;

    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk_i};
            r_dat_sync <= {r_dat_sync[0], ps2_data_i};
        end
    end

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];

    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic [FIFO_AW:0] w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             r_overflow;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == DEPTH_L);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = tx_valid && !w_full;

    // NOTE: the storage array is deliberately left without reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (FIFO_AW + 1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (FIFO_AW + 1)'(1);
            r_overflow <= tx_valid && w_full;
        end
    end

    logic [7:0]  w_head;
    logic [10:0] w_frame;

    assign w_head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    // Frame bit n is the value presented in bit cell n: start, D0..D7, odd parity, stop.
    assign w_frame = {1'b1, ~^w_head, w_head, 1'b0};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_bit;
    logic [3:0]       w_bit_nxt;
    logic             r_clk_o;
    logic             r_dat_o;
    logic             w_clk_nxt;
    logic             w_dat_nxt;

    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_clk_o <= 1'b1;
            r_dat_o <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_clk_o <= w_clk_nxt;
            r_dat_o <= w_dat_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit;
        w_pop       = 1'b0;
        w_clk_nxt   = 1'b1;
        w_dat_nxt   = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_empty) w_state_nxt = S_IDLE_CHK;
            end
            S_IDLE_CHK: begin
                if (!(w_clk_s && w_dat_s)) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == HALF_LAST) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            S_HIGH: begin
                // The first cycles after our own release still see the old low level through the synchroniser.
                if (!w_clk_s && (r_cnt >= BLANK)) begin
                    w_state_nxt = S_ABORT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == HALF_LAST) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            S_LOW: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_bit == LAST_BIT) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_bit_nxt   = r_bit + 4'd1;
                        w_state_nxt = S_HIGH;
                    end
                end
            end
            S_ABORT: begin
                w_state_nxt = S_IDLE_CHK;
                w_cnt_nxt   = '0;
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_state_nxt == S_HIGH) begin
            w_dat_nxt = w_frame[w_bit_nxt];
        end else if (w_state_nxt == S_LOW) begin
            w_clk_nxt = 1'b0;
            w_dat_nxt = w_frame[w_bit_nxt];
        end
    end

    assign ps2_clk_o  = r_clk_o;
    assign ps2_data_o = r_dat_o;
    assign tx_ready   = !w_full;
    assign overflow   = r_overflow;
    assign fifo_level = w_level;
    assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Directed bench for ps2_dev_tx: frame vectors from a table, then inhibit, RTS,
// overflow and mid-frame reset sequences. Host lines are modelled as wired-AND.
module tb_ps2_dev_tx;

    localparam int CH = 4;
    localparam int AW = 3;

    logic          clk_sys  = 1'b0;
    logic          reset_n  = 1'b0;
    logic [7:0]    tx_data  = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          overflow;
    logic [AW:0]   fifo_level;
    logic          busy;
    logic          ps2_clk_o;
    logic          ps2_data_o;
    logic          ext_clk = 1'b1;
    logic          ext_dat = 1'b1;
    logic          ps2_clk_i;
    logic          ps2_data_i;

    assign ps2_clk_i  = ps2_clk_o & ext_clk;
    assign ps2_data_i = ps2_data_o & ext_dat;

    ps2_dev_tx #(.CLK_HALF(CH), .FIFO_AW(AW)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .overflow   (overflow),
        .fifo_level (fifo_level),
        .busy       (busy),
        .ps2_clk_o  (ps2_clk_o),
        .ps2_data_o (ps2_data_o),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line monitor, sampled on the falling system-clock edge.
    int          cyc = 0;
    int          fall_t[$];
    logic        fall_d[$];
    int          rise_t[$];
    int          start_t[$];
    int          lvl0_t  = -1;
    int          busyf_t = -1;
    int          ovf_n   = 0;
    logic        p_c = 1'b1;
    logic        p_d = 1'b1;
    logic        p_b = 1'b0;
    logic [AW:0] p_l = '0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (p_c && !ps2_clk_o) begin
            fall_t.push_back(cyc);
            fall_d.push_back(ps2_data_o);
        end
        if (!p_c && ps2_clk_o) rise_t.push_back(cyc);
        if (p_c && ps2_clk_o && p_d && !ps2_data_o) start_t.push_back(cyc);
        if (p_l != 0 && fifo_level == 0) lvl0_t <= cyc;
        if (p_b && !busy) busyf_t <= cyc;
        if (overflow) ovf_n <= ovf_n + 1;
        p_c <= ps2_clk_o;
        p_d <= ps2_data_o;
        p_b <= busy;
        p_l <= fifo_level;
    end

    task automatic clear_mon();
        fall_t.delete();
        fall_d.delete();
        rise_t.delete();
        start_t.delete();
        lvl0_t  = -1;
        busyf_t = -1;
        ovf_n   = 0;
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk_sys);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk_sys);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name);
        int k = 0;
        while (busy && k < max) begin
            @(negedge clk_sys);
            k++;
        end
        check({name, " idle"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic wait_falls(input int n, input int max, input string name);
        int k = 0;
        while (fall_t.size() < n && k < max) begin
            @(negedge clk_sys);
            k++;
        end
        check({name, " falls reached"}, 32'(fall_t.size() >= n), 32'd1);
    endtask

    function automatic logic [10:0] frame_at(input int base);
        logic [10:0] f = '0;
        for (int i = 0; i < 11; i++)
            if (base + i < fall_d.size()) f[i] = fall_d[base + i];
        return f;
    endfunction

    // frame holds the data seen at falling edges 0..10: {stop, parity, D7..D0, start}.
    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int rel;
        vecs[0] = '{8'h1C, 11'b1_0_00011100_0};
        vecs[1] = '{8'hF0, 11'b1_1_11110000_0};
        vecs[2] = '{8'h00, 11'b1_1_00000000_0};
        vecs[3] = '{8'hFF, 11'b1_1_11111111_0};
        vecs[4] = '{8'hA5, 11'b1_1_10100101_0};
        vecs[5] = '{8'h01, 11'b1_0_00000001_0};

        repeat (3) @(negedge clk_sys);
        check("reset clk_o", 32'(ps2_clk_o), 32'd1);
        check("reset data_o", 32'(ps2_data_o), 32'd1);
        check("reset tx_ready", 32'(tx_ready), 32'd1);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset level", 32'(fifo_level), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);

        for (int v = 0; v < 6; v++) begin
            clear_mon();
            push(vecs[v].data);
            wait_idle(300, $sformatf("vec%0d", v));
            check($sformatf("vec%0d falls", v), 32'(fall_t.size()), 32'd11);
            check($sformatf("vec%0d frame", v), 32'(frame_at(0)), 32'(vecs[v].frame));
            check($sformatf("vec%0d starts", v), 32'(start_t.size()), 32'd1);
            check($sformatf("vec%0d frame length", v),
                  (rise_t.size() > 0 && start_t.size() > 0) ? 32'(rise_t[$] - start_t[0]) : 32'hFFFF_FFFF,
                  32'd88);
            check($sformatf("vec%0d busy tail", v), 32'(busyf_t - lvl0_t), 32'd8);
            check($sformatf("vec%0d level", v), 32'(fifo_level), 32'd0);
        end

        // Back-to-back bytes: two frames separated by LOW tail + GAP + IDLE_CHK.
        clear_mon();
        @(negedge clk_sys);
        tx_valid = 1'b1;
        tx_data  = 8'hF0;
        @(negedge clk_sys);
        tx_data  = 8'h00;
        @(negedge clk_sys);
        tx_valid = 1'b0;
        wait_idle(600, "b2b");
        check("b2b falls", 32'(fall_t.size()), 32'd22);
        check("b2b frame1", 32'(frame_at(0)), 32'(11'b1_1_11110000_0));
        check("b2b frame2", 32'(frame_at(11)), 32'(11'b1_1_00000000_0));
        check("b2b starts", 32'(start_t.size()), 32'd2);
        check("b2b gap", (start_t.size() > 1 && fall_t.size() > 10) ? 32'(start_t[1] - fall_t[10] >= 16) : 32'd0,
              32'd1);

        // Host inhibit during bit 5 HIGH phase of 0x1C.
        clear_mon();
        push(8'h1C);
        wait_falls(5, 200, "abort");
        for (int k = 0; k < 20 && !ps2_clk_o; k++) @(negedge clk_sys);
        @(negedge clk_sys);
        ext_clk = 1'b0;
        repeat (20) @(negedge clk_sys);
        check("abort falls frozen", 32'(fall_t.size()), 32'd5);
        check("abort clk_o", 32'(ps2_clk_o), 32'd1);
        check("abort data_o", 32'(ps2_data_o), 32'd1);
        check("abort no pop", 32'(fifo_level), 32'd1);
        @(negedge clk_sys);
        ext_clk = 1'b1;
        rel = cyc;
        wait_idle(300, "abort retx");
        check("abort starts", 32'(start_t.size()), 32'd2);
        check("abort restart delay", (start_t.size() > 1) ? 32'(start_t[1] - rel) : 32'hFFFF_FFFF, 32'd6);
        check("abort total falls", 32'(fall_t.size()), 32'd16);
        check("abort retx frame", 32'(frame_at(5)), 32'(11'b1_0_00011100_0));
        check("abort popped", 32'(fifo_level), 32'd0);

        // Host request-to-send holds data low.
        clear_mon();
        @(negedge clk_sys);
        ext_dat = 1'b0;
        repeat (3) @(negedge clk_sys);
        push(8'h55);
        repeat (30) @(negedge clk_sys);
        check("rts no falls", 32'(fall_t.size()), 32'd0);
        check("rts level", 32'(fifo_level), 32'd1);
        check("rts busy", 32'(busy), 32'd1);
        @(negedge clk_sys);
        ext_dat = 1'b1;
        rel = cyc;
        wait_idle(300, "rts");
        check("rts start delay", (start_t.size() > 0) ? 32'(start_t[0] - rel) : 32'hFFFF_FFFF, 32'd6);
        check("rts falls", 32'(fall_t.size()), 32'd11);
        check("rts frame", 32'(frame_at(0)), 32'(11'b1_1_01010101_0));

        // Overflow: nine pushes while the host inhibits.
        @(negedge clk_sys);
        ext_clk = 1'b0;
        repeat (3) @(negedge clk_sys);
        clear_mon();
        tx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tx_data = 8'h10 + 8'(i);
            @(negedge clk_sys);
        end
        tx_valid = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("ovf pulse count", 32'(ovf_n), 32'd1);
        check("ovf overflow low", 32'(overflow), 32'd0);
        check("ovf tx_ready", 32'(tx_ready), 32'd0);
        check("ovf level", 32'(fifo_level), 32'd8);
        check("ovf no falls", 32'(fall_t.size()), 32'd0);
        reset_n = 1'b0;
        #1;
        check("ovf flush level", 32'(fifo_level), 32'd0);
        @(negedge clk_sys);
        ext_clk = 1'b1;
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);

        // Reset in the middle of a frame with three bytes queued.
        clear_mon();
        @(negedge clk_sys);
        tx_valid = 1'b1;
        tx_data  = 8'hA1;
        @(negedge clk_sys);
        tx_data  = 8'hB2;
        @(negedge clk_sys);
        tx_data  = 8'hC3;
        @(negedge clk_sys);
        tx_valid = 1'b0;
        wait_falls(3, 200, "midrst");
        for (int k = 0; k < 20 && ps2_clk_o; k++) @(negedge clk_sys);
        check("midrst clk low before reset", 32'(ps2_clk_o), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst clk_o", 32'(ps2_clk_o), 32'd1);
        check("midrst data_o", 32'(ps2_data_o), 32'd1);
        check("midrst level", 32'(fifo_level), 32'd0);
        check("midrst tx_ready", 32'(tx_ready), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        clear_mon();
        repeat (200) @(negedge clk_sys);
        check("midrst no frame", 32'(fall_t.size()), 32'd0);
        check("midrst no start", 32'(start_t.size()), 32'd0);
        check("midrst idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
